fp_mult_pipe: RTL

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_norm_round.sv | 69 ++++++
 rtl/fp_mult_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared types and helpers for the pipelined FP multiplier.
// Holds the operand class enum, flag bit indices, bias and canonical-NaN helpers.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INV = 0;

  function automatic int fp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // Sign 0, exponent all ones, fraction MSB set; caller trims to word width.
  function automatic logic [63:0] fp_qnan(input int e, input int f);
    logic [63:0] one;
    one = 64'd1;
    return (((one << e) - one) << f) | (one << (f - 1));
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: S3 normalise, round, overflow/underflow detect (combinational).
// Ports: sign_i, exp_i (unbiased-sum exponent), prod_i (mantissa product) -> y_o, flag_o.
// Macro FP_MULT_ROUND_EN selects round-to-nearest-even; otherwise truncation.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic                  sign_i,
  input  logic signed [EXP+1:0] exp_i,
  input  logic [2*FRA+1:0]      prod_i,
  output logic [EXP+FRA:0]      y_o,
  output logic [2:0]            flag_o
);

  localparam int EW = EXP + 2;
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] ZERO = EW'(0);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP) - 1);
  localparam logic [EXP-1:0] EONES = '1;

  logic                 hi;
  logic [FRA-1:0]       frac_t;
  logic [FRA-1:0]       frac;
  logic signed [EW-1:0] e_n;
  logic signed [EW-1:0] e_r;
  logic                 ovf;
  logic                 unf;

  // Product in [2,4) when the top bit is set: take one extra right shift.
  assign hi     = prod_i[2*FRA+1];
  assign frac_t = FRA'(prod_i >> (hi ? FRA + 1 : FRA));
  assign e_n    = hi ? exp_i + ONE : exp_i;

`ifdef FP_MULT_ROUND_EN
  logic           guard;
  logic           sticky;
  logic           inc;
  logic [FRA:0]   sum;

  assign guard  = hi ? prod_i[FRA] : prod_i[FRA-1];
  assign sticky = hi ? |prod_i[FRA-1:0] : |prod_i[FRA-2:0];
  assign inc    = guard & (sticky | frac_t[0]);
  assign sum    = {1'b0, frac_t} + {{FRA{1'b0}}, inc};
  // A carry out means the fraction wrapped to zero: mantissa is 2.0.
  assign frac   = sum[FRA-1:0];
  assign e_r    = sum[FRA] ? e_n + ONE : e_n;
`else
  assign frac   = frac_t;
  assign e_r    = e_n;
`endif

  assign ovf = e_r >= EMAX;
  assign unf = e_r <= ZERO;

  always_comb begin
    flag_o = '0;
    y_o    = {sign_i, e_r[EXP-1:0], frac};
    if (ovf) begin
      y_o             = {sign_i, EONES, {FRA{1'b0}}};
      flag_o[FLG_OVF] = 1'b1;
    end else if (unf) begin
      y_o             = {sign_i, {(EXP+FRA){1'b0}}};
      flag_o[FLG_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage FP multiplier with valid/ready and global stall.
// Ports: sys_clk, sys_rst, in_valid/in_ready, A, B, out_valid/out_ready, Y, flag[2:0]
// (flag: [2] overflow, [1] underflow, [0] invalid). Macro FP_MULT_ROUND_EN: RNE rounding.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP+FRA:0] A,
  input  logic [EXP+FRA:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP+FRA:0] Y,
  output logic [2:0]       flag
);

  localparam int W  = EXP + FRA + 1;
  localparam int MW = FRA + 1;
  localparam int PW = 2 * FRA + 2;
  localparam int EW = EXP + 2;
  localparam logic [EXP-1:0]       EONES = '1;
  localparam logic signed [EW-1:0] BIAS  = EW'(fp_bias(EXP));
  localparam logic [W-1:0]         QNAN  = W'(fp_qnan(EXP, FRA));

  logic                 en;

  logic [EXP-1:0]       ea;
  logic [EXP-1:0]       eb;
  logic [FRA-1:0]       fa;
  logic [FRA-1:0]       fb;
  fp_cls_e              ca;
  fp_cls_e              cb;
  fp_cls_e              c_d;
  logic signed [EW-1:0] e_d;

  logic                 v1_q;
  logic                 s1_q;
  fp_cls_e              c1_q;
  logic signed [EW-1:0] e1_q;
  logic [MW-1:0]        ma1_q;
  logic [MW-1:0]        mb1_q;

  logic                 v2_q;
  logic                 s2_q;
  fp_cls_e              c2_q;
  logic signed [EW-1:0] e2_q;
  logic [PW-1:0]        p2_q;

  logic                 out_valid_q;
  logic [W-1:0]         y_q;
  logic [2:0]           flag_q;

  logic [W-1:0]         nr_y;
  logic [2:0]           nr_flag;
  logic [W-1:0]         y_d;
  logic [2:0]           flag_d;

  // One enable for every stage: the pipe only moves when the output drains.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign ea = A[W-2:FRA];
  assign eb = B[W-2:FRA];
  assign fa = A[FRA-1:0];
  assign fb = B[FRA-1:0];

  // Subnormals fall in the zero class.
  assign ca = (ea == EONES) ? ((fa == '0) ? CLS_INF : CLS_NAN)
            : (ea == '0)    ? CLS_ZERO : CLS_NORM;
  assign cb = (eb == EONES) ? ((fb == '0) ? CLS_INF : CLS_NAN)
            : (eb == '0)    ? CLS_ZERO : CLS_NORM;

  always_comb begin
    c_d = CLS_NORM;
    if (ca == CLS_NAN || cb == CLS_NAN)
      c_d = CLS_NAN;
    else if ((ca == CLS_INF && cb == CLS_ZERO) ||
             (ca == CLS_ZERO && cb == CLS_INF))
      c_d = CLS_NAN;
    else if (ca == CLS_INF || cb == CLS_INF)
      c_d = CLS_INF;
    else if (ca == CLS_ZERO || cb == CLS_ZERO)
      c_d = CLS_ZERO;
  end

  assign e_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  fp_norm_round #(
    .EXP (EXP),
    .FRA (FRA)
  ) u_norm_round (
    .sign_i (s2_q),
    .exp_i  (e2_q),
    .prod_i (p2_q),
    .y_o    (nr_y),
    .flag_o (nr_flag)
  );

  always_comb begin
    y_d    = '0;
    flag_d = '0;
    unique case (c2_q)
      CLS_NAN: begin
        y_d             = QNAN;
        flag_d[FLG_INV] = 1'b1;
      end
      CLS_INF:  y_d = {s2_q, EONES, {FRA{1'b0}}};
      CLS_ZERO: y_d = {s2_q, {(W-1){1'b0}}};
      default: begin
        y_d    = nr_y;
        flag_d = nr_flag;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      c1_q        <= CLS_ZERO;
      e1_q        <= '0;
      ma1_q       <= '0;
      mb1_q       <= '0;
      v2_q        <= 1'b0;
      s2_q        <= 1'b0;
      c2_q        <= CLS_ZERO;
      e2_q        <= '0;
      p2_q        <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flag_q      <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_q  <= A[W-1] ^ B[W-1];
        c1_q  <= c_d;
        e1_q  <= e_d;
        ma1_q <= {1'b1, fa};
        mb1_q <= {1'b1, fb};
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q <= s1_q;
        c2_q <= c1_q;
        e2_q <= e1_q;
        p2_q <= PW'(ma1_q) * PW'(mb1_q);
      end
      out_valid_q <= v2_q;
      if (v2_q) begin
        y_q    <= y_d;
        flag_q <= flag_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign flag      = flag_q;

endmodule
